// File: rtl/quiz_sequencer.sv
// rtl/quiz_sequencer.sv - LFSR-driven question master: issues operands/opcode, grades answers, times out, keeps score.
// Optional feature macro QUIZ_DIV_EN: when defined, division (opcode 11) is issued; otherwise it is remapped to add.
module quiz_sequencer #(
  parameter int unsigned NUM_ROUNDS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] operand1,
  output logic [3:0] operand2,
  output logic [1:0] opcode,
  input  logic [7:0] exp_result,
  output logic       q_valid,
  input  logic       ans_valid,
  input  logic [7:0] ans_data,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic [7:0] score,
  output logic [7:0] round,
  output logic       done
);

  localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ROUNDS_LAST  = 8'(NUM_ROUNDS);
  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_ASK, S_EVAL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    op1_q, op1_d, op2_q, op2_d;
  logic [1:0]    opc_q, opc_d;
  logic          q_valid_q, q_valid_d;
  logic          correct_q, correct_d, wrong_q, wrong_d, timeout_q, timeout_d;
  logic [7:0]    score_q, score_d, round_q, round_d;
  logic          done_q, done_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    ans_q, ans_d;

  logic [15:0]   lfsr_adv;
  logic [3:0]    gen_op1, gen_op2;
  logic [1:0]    gen_opc;
  logic [7:0]    round_inc;

  // Advance the LFSR once and legalise the operand pair taken from the new value
  always_comb begin
    lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    gen_op1  = lfsr_adv[3:0];
    gen_op2  = lfsr_adv[7:4];
    gen_opc  = lfsr_adv[9:8];
`ifdef QUIZ_DIV_EN
    if (gen_opc == 2'b11 && gen_op2 == 4'd0) begin
      gen_op2 = 4'd1;
    end
`else
    if (gen_opc == 2'b11) begin
      gen_opc = 2'b00;
    end
`endif
    if (gen_opc == 2'b01 && gen_op1 < gen_op2) begin
      gen_op1 = lfsr_adv[7:4];
      gen_op2 = lfsr_adv[3:0];
    end
  end

  assign round_inc = round_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    opc_d     = opc_q;
    q_valid_d = q_valid_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    timeout_d = 1'b0;
    score_d   = score_q;
    round_d   = round_q;
    done_d    = done_q;
    timer_d   = timer_q;
    ans_d     = ans_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_GEN;
          score_d = 8'd0;
          round_d = 8'd0;
          done_d  = 1'b0;
        end
      end
      S_GEN: begin
        lfsr_d    = lfsr_adv;
        op1_d     = gen_op1;
        op2_d     = gen_op2;
        opc_d     = gen_opc;
        q_valid_d = 1'b1;
        timer_d   = '0;
        state_d   = S_ASK;
      end
      S_ASK: begin
        // An answer in the expiry cycle takes priority over the timeout
        if (ans_valid) begin
          ans_d     = ans_data;
          q_valid_d = 1'b0;
          state_d   = S_EVAL;
        end else if (timer_q == T_LAST) begin
          timeout_d = 1'b1;
          q_valid_d = 1'b0;
          round_d   = round_inc;
          if (round_inc == ROUNDS_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GEN;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (ans_q == exp_result) begin
          correct_d = 1'b1;
          score_d   = score_q + 8'd1;
        end else begin
          wrong_d = 1'b1;
        end
        round_d = round_inc;
        if (round_inc == ROUNDS_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_GEN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      op1_q     <= 4'd0;
      op2_q     <= 4'd0;
      opc_q     <= 2'd0;
      q_valid_q <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
      score_q   <= 8'd0;
      round_q   <= 8'd0;
      done_q    <= 1'b0;
      timer_q   <= '0;
      ans_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      opc_q     <= opc_d;
      q_valid_q <= q_valid_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      timeout_q <= timeout_d;
      score_q   <= score_d;
      round_q   <= round_d;
      done_q    <= done_d;
      timer_q   <= timer_d;
      ans_q     <= ans_d;
    end
  end

  assign operand1 = op1_q;
  assign operand2 = op2_q;
  assign opcode   = opc_q;
  assign q_valid  = q_valid_q;
  assign correct  = correct_q;
  assign wrong    = wrong_q;
  assign timeout  = timeout_q;
  assign score    = score_q;
  assign round    = round_q;
  assign done     = done_q;

endmodule
